// File: rtl/servo_pkg.sv
// servo_pkg: shared widths, default frame timing and the
// position-to-pulse-width mapping used by the servo driver.
package servo_pkg;

  localparam int CNT_W = 19;
  localparam int POS_W = 8;

  localparam int unsigned DEF_PERIOD_TICKS = 500000;
  localparam int unsigned DEF_PULSE_MIN    = 25000;
  localparam int unsigned DEF_PULSE_STEP   = 98;
  localparam int unsigned DEF_POS_RESET    = 128;

  localparam int unsigned POS_TOP = 2**POS_W - 1;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [POS_W-1:0] pos_t;

  localparam pos_t POS_MAX = '1;
  localparam pos_t POS_MIN = '0;

  typedef enum logic [1:0] {
    MV_HOLD = 2'd0,
    MV_UP   = 2'd1,
    MV_DOWN = 2'd2
  } move_e;

  // 32-bit product; the top checks at elaboration that it fits CNT_W
  function automatic cnt_t pulse_ticks(
    input pos_t        pos,
    input int unsigned pmin,
    input int unsigned pstep
  );
    int unsigned w;
    w = pmin + 32'(pos) * pstep;
    return cnt_t'(w);
  endfunction

endpackage

// File: rtl/servo_pwm_driver_btn_sync.sv
// btn_sync: two-flop synchronizer for one asynchronous
// push button, cleared by the synchronous reset.
module btn_sync (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic level
);

  logic meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta  <= 1'b0;
      level <= 1'b0;
    end else begin
      meta  <= btn;
      level <= meta;
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver: button-driven servo position with a
// frame-locked, glitch-free PWM output on the system clock.
module servo_pwm_driver
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS = DEF_PERIOD_TICKS,
  parameter int unsigned PULSE_MIN    = DEF_PULSE_MIN,
  parameter int unsigned PULSE_STEP   = DEF_PULSE_STEP,
  parameter int unsigned POS_RESET    = DEF_POS_RESET
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clk_div,
  input  logic             btn_up,
  input  logic             btn_down,
  output logic             pwm,
  output logic [POS_W-1:0] position,
  output logic             frame_start
);

  localparam cnt_t LAST     = cnt_t'(PERIOD_TICKS - 1);
  localparam pos_t POS_INIT = pos_t'(POS_RESET);
  localparam cnt_t W_INIT   =
    pulse_ticks(POS_INIT, PULSE_MIN, PULSE_STEP);

  if (PULSE_MIN + POS_TOP * PULSE_STEP >= PERIOD_TICKS)
  begin : g_width_chk
    $error("servo_pwm_driver: widest pulse exceeds frame");
  end

  if (PERIOD_TICKS > 2**CNT_W || PERIOD_TICKS < 2)
  begin : g_period_chk
    $error("servo_pwm_driver: PERIOD_TICKS out of range");
  end

  if (POS_RESET > POS_TOP) begin : g_pos_chk
    $error("servo_pwm_driver: POS_RESET out of range");
  end

  logic  clk_div_q;
  logic  tick;
  logic  wrap;
  logic  up_s;
  logic  down_s;
  cnt_t  cnt;
  cnt_t  width_q;
  pos_t  pos_next;
  move_e move;

  btn_sync u_sync_up (
    .clock (clock),
    .reset (reset),
    .btn   (btn_up),
    .level (up_s)
  );

  btn_sync u_sync_down (
    .clock (clock),
    .reset (reset),
    .btn   (btn_down),
    .level (down_s)
  );

  // clk_div is data: rising edge becomes a one-cycle enable
  assign tick = clk_div & ~clk_div_q;
  assign wrap = tick & (cnt == LAST);

  always_comb begin
    move = MV_HOLD;
    unique case (1'b1)
      up_s & ~down_s & (position != POS_MAX):
        move = MV_UP;
      down_s & ~up_s & (position != POS_MIN):
        move = MV_DOWN;
      default:
        move = MV_HOLD;
    endcase
  end

  always_comb begin
    pos_next = position;
    if (wrap) begin
      unique case (move)
        MV_UP:   pos_next = position + 1'b1;
        MV_DOWN: pos_next = position - 1'b1;
        default: pos_next = position;
      endcase
    end
  end

  // width_q only moves at the wrap, so a pulse is never cut
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_div_q   <= 1'b1;
      cnt         <= '0;
      position    <= POS_INIT;
      width_q     <= W_INIT;
      pwm         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      clk_div_q   <= clk_div;
      frame_start <= wrap;
      position    <= pos_next;
      pwm         <= (cnt < width_q);
      if (tick) begin
        cnt <= wrap ? '0 : cnt + 1'b1;
      end
      if (wrap) begin
        width_q <= pulse_ticks(pos_next, PULSE_MIN,
                               PULSE_STEP);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb_servo_pwm_driver: scoreboard bench; expected position and
// pulse length per frame are queued and checked at frame_start.
module tb_servo_pwm_driver;

  localparam int PT    = 640;
  localparam int PMIN  = 100;
  localparam int PSTEP = 2;
  localparam int PRST  = 128;
  localparam int TPC   = 2;
  localparam int LORST = 3;
  localparam int HIRST = 252;

  logic       clock    = 1'b0;
  logic       reset    = 1'b1;
  logic       clk_div  = 1'b0;
  logic       btn_up   = 1'b0;
  logic       btn_down = 1'b0;
  logic       pwm;
  logic       frame_start;
  logic [7:0] position;

  logic       up_lo = 1'b0, down_lo = 1'b0;
  logic       up_hi = 1'b0, down_hi = 1'b0;
  logic       pwm_lo, pwm_hi, fs_lo, fs_hi;
  logic [7:0] pos_lo, pos_hi;

  servo_pwm_driver #(
    .PERIOD_TICKS (PT),
    .PULSE_MIN    (PMIN),
    .PULSE_STEP   (PSTEP),
    .POS_RESET    (PRST)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .clk_div     (clk_div),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .pwm         (pwm),
    .position    (position),
    .frame_start (frame_start)
  );

  servo_pwm_driver #(
    .PERIOD_TICKS (PT),
    .PULSE_MIN    (PMIN),
    .PULSE_STEP   (PSTEP),
    .POS_RESET    (LORST)
  ) dut_lo (
    .clock       (clock),
    .reset       (reset),
    .clk_div     (clk_div),
    .btn_up      (up_lo),
    .btn_down    (down_lo),
    .pwm         (pwm_lo),
    .position    (pos_lo),
    .frame_start (fs_lo)
  );

  servo_pwm_driver #(
    .PERIOD_TICKS (PT),
    .PULSE_MIN    (PMIN),
    .PULSE_STEP   (PSTEP),
    .POS_RESET    (HIRST)
  ) dut_hi (
    .clock       (clock),
    .reset       (reset),
    .clk_div     (clk_div),
    .btn_up      (up_hi),
    .btn_down    (down_hi),
    .pwm         (pwm_hi),
    .position    (pos_hi),
    .frame_start (fs_hi)
  );

  always #5 clock = ~clock;

  initial begin
    forever #10 clk_div = ~clk_div;
  end

  typedef struct {
    int pos;
    int width;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   exp_pos = PRST;

  function automatic int model_width(input int p);
    return PMIN + PSTEP * p;
  endfunction

  // frame monitor for the main instance
  int hi_cnt = 0;
  int cyc = 0;
  int pend_w = 0;
  bit pend_v = 1'b0;
  bit per_v = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      hi_cnt = 0;
      cyc    = 0;
      pend_w = model_width(PRST);
      pend_v = 1'b1;
      per_v  = 1'b0;
    end else if (frame_start) begin
      if (pend_v) begin
        checks++;
        if (hi_cnt !== TPC * pend_w)
          $display("FAIL pulse_len got %0d clocks want %0d",
                   hi_cnt, TPC * pend_w);
        else passes++;
      end
      if (per_v) begin
        checks++;
        if (cyc !== TPC * PT)
          $display("FAIL frame_period got %0d want %0d",
                   cyc, TPC * PT);
        else passes++;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (position !== 8'(e.pos))
          $display("FAIL frame_pos got %0d want %0d",
                   position, e.pos);
        else passes++;
        pend_w = e.width;
        pend_v = 1'b1;
      end else begin
        pend_v = 1'b0;
      end
      hi_cnt = 0;
      cyc    = 1;
      per_v  = 1'b1;
    end else begin
      hi_cnt += int'(pwm);
      cyc++;
    end
  end

  task automatic wait_frame();
    for (int i = 0; i < 4 * TPC * PT; i++) begin
      @(negedge clock);
      if (frame_start) return;
    end
    checks++;
    $display("FAIL frame_timeout no frame_start seen");
  endtask

  task automatic run_frames(input int n, input bit up,
                            input bit dn);
    for (int i = 0; i < n; i++) begin
      btn_up   = up;
      btn_down = dn;
      if (up && !dn && exp_pos < 255) exp_pos++;
      else if (dn && !up && exp_pos > 0) exp_pos--;
      q.push_back('{pos: exp_pos,
                    width: model_width(exp_pos)});
      wait_frame();
    end
  endtask

  task automatic inst_frame(input bit sel, output int hi,
                            output bit ok);
    hi = 0;
    ok = 1'b0;
    for (int i = 0; i < 4 * TPC * PT; i++) begin
      @(negedge clock);
      if (sel ? fs_hi : fs_lo) begin
        ok = 1'b1;
        return;
      end
      hi += int'(sel ? pwm_hi : pwm_lo);
    end
  endtask

  // release reset right after a tick edge
  task automatic release_aligned();
    @(posedge clk_div);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (6) @(posedge clock);
    release_aligned();
    @(negedge clock);
    checks++;
    if (pwm !== 1'b0)
      $display("FAIL rst_pwm got %b want 0", pwm);
    else passes++;
    checks++;
    if (position !== 8'(PRST))
      $display("FAIL rst_pos got %0d want %0d",
               position, PRST);
    else passes++;
    checks++;
    if (frame_start !== 1'b0)
      $display("FAIL rst_fs got %b want 0", frame_start);
    else passes++;
    checks++;
    if (dut.cnt !== 19'd0)
      $display("FAIL rst_cnt got %0d want 0", dut.cnt);
    else passes++;
    exp_pos = PRST;
  endtask

  task automatic test_idle();
    run_frames(3, 1'b0, 1'b0);
  endtask

  task automatic test_both_hold();
    run_frames(5, 1'b1, 1'b1);
    btn_up   = 1'b0;
    btn_down = 1'b0;
  endtask

  task automatic test_glitch();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (150) @(posedge clock);
    #1 btn_up = 1'b1;
    repeat (TPC) @(posedge clock);
    #1 btn_up = 1'b0;
    q.push_back('{pos: exp_pos,
                  width: model_width(exp_pos)});
    wait_frame();
  endtask

  task automatic test_up_hold();
    run_frames(3, 1'b1, 1'b0);
    btn_up = 1'b0;
  endtask

  task automatic test_mid_frame();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (100) @(posedge clock);
    #1 btn_up = 1'b1;
    repeat (10) @(negedge clock);
    checks++;
    if (position !== 8'(exp_pos))
      $display("FAIL mid_pos got %0d want %0d",
               position, exp_pos);
    else passes++;
    exp_pos++;
    q.push_back('{pos: exp_pos,
                  width: model_width(exp_pos)});
    wait_frame();
    btn_up = 1'b0;
    q.push_back('{pos: exp_pos,
                  width: model_width(exp_pos)});
    wait_frame();
  endtask

  task automatic test_reset_mid();
    run_frames(140 - exp_pos, 1'b1, 1'b0);
    btn_up = 1'b0;
    repeat (500 * TPC) @(posedge clock);
    @(negedge clock);
    checks++;
    if (pwm !== 1'b0 || position !== 8'd140)
      $display("FAIL pre_rst got pwm=%b pos=%0d want 0/140",
               pwm, position);
    else passes++;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (pwm !== 1'b0)
      $display("FAIL mid_rst_pwm got %b want 0", pwm);
    else passes++;
    checks++;
    if (dut.cnt !== 19'd0)
      $display("FAIL mid_rst_cnt got %0d want 0", dut.cnt);
    else passes++;
    checks++;
    if (position !== 8'(PRST))
      $display("FAIL mid_rst_pos got %0d want %0d",
               position, PRST);
    else passes++;
    exp_pos = PRST;
    run_frames(2, 1'b0, 1'b0);
  endtask

  task automatic test_saturate(input bit sel);
    int hi;
    bit ok;
    int e;
    int pw;
    e = sel ? HIRST : LORST;
    inst_frame(sel, hi, ok);
    if (!ok) begin
      checks++;
      $display("FAIL sat_sync_timeout sel=%0d", sel);
      return;
    end
    if (sel) up_hi = 1'b1;
    else down_lo = 1'b1;
    pw = model_width(e);
    for (int f = 0; f < 6; f++) begin
      inst_frame(sel, hi, ok);
      if (!ok) begin
        checks++;
        $display("FAIL sat_timeout sel=%0d", sel);
        return;
      end
      if (sel && e < 255) e++;
      else if (!sel && e > 0) e--;
      checks++;
      if ((sel ? pos_hi : pos_lo) !== 8'(e))
        $display("FAIL sat_pos sel=%0d got %0d want %0d",
                 sel, sel ? pos_hi : pos_lo, e);
      else passes++;
      checks++;
      if (hi !== TPC * pw)
        $display("FAIL sat_pulse sel=%0d got %0d want %0d",
                 sel, hi, TPC * pw);
      else passes++;
      pw = model_width(e);
    end
    up_hi   = 1'b0;
    down_lo = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_both_hold();
    test_glitch();
    test_up_hold();
    test_mid_frame();
    test_reset_mid();
    test_saturate(1'b0);
    test_saturate(1'b1);
    checks++;
    if (q.size() !== 0)
      $display("FAIL sb_leftover got %0d want 0", q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
